// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU op scheduler.
// Optional feature macro: ALU_SCHED_RR_EN (see alu_op_scheduler.sv).
package alu_sched_pkg;

  localparam int unsigned NREQ             = 4;
  localparam int unsigned OPW              = 4;
  localparam int unsigned SELW             = 1 << OPW;
  localparam int unsigned LONG_LAT_DEF     = 4;
  localparam int unsigned LONG_OP_BASE_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  // Execution latency in cycles: long_lat for opcodes at/above long_base, else 1.
  function automatic logic [3:0] op_latency(input logic [OPW-1:0] op,
                                            input int unsigned    long_lat,
                                            input int unsigned    long_base);
    return (32'(op) >= long_base) ? 4'(long_lat) : 4'd1;
  endfunction

endpackage

// File: rtl/op_onehot_decode.sv
// Combinational 4-to-16 one-hot decode of an ALU opcode.
module op_onehot_decode
  import alu_sched_pkg::*;
(
  input  logic [OPW-1:0]  op,
  output logic [SELW-1:0] sel
);

  always_comb begin
    sel     = '0;
    sel[op] = 1'b1;
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Arbitrates four requesters onto a shared ALU and drives its one-hot function select.
// Macro ALU_SCHED_RR_EN: round-robin arbitration; undefined gives fixed priority (req[0] highest).
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned LONG_LAT     = LONG_LAT_DEF,
  parameter int unsigned LONG_OP_BASE = LONG_OP_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] op_i,
  output logic [3:0]  grant,
  output logic [15:0] alu_sel,
  output logic        alu_busy,
  output logic [3:0]  done
);

  state_t          state;
  logic [3:0]      cnt;
  logic [OPW-1:0]  op_q;
  logic [OPW-1:0]  op_sel;
  logic [OPW-1:0]  dec_in;
  logic [SELW-1:0] dec_sel;
  logic [3:0]      lat_sel;
  logic [1:0]      win_nx;
  logic            any_req;

`ifdef ALU_SCHED_RR_EN
  logic [1:0] ptr;
  logic [1:0] idx;

  // Scan from farthest to nearest offset so the first requester after ptr wins.
  always_comb begin
    win_nx = '0;
    idx    = '0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) win_nx = idx;
    end
  end
`else
  always_comb begin
    win_nx = '0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      if (req[i-1]) win_nx = 2'(i - 1);
    end
  end
`endif

  assign any_req = |req;
  assign op_sel  = op_i[32'(win_nx)*OPW +: OPW];
  assign lat_sel = op_latency(op_sel, LONG_LAT, LONG_OP_BASE);

  // In IDLE the decoder sees the opcode being latched so alu_sel is valid in the first EXEC cycle.
  assign dec_in = (state == IDLE) ? op_sel : op_q;

  op_onehot_decode u_dec (
    .op  (dec_in),
    .sel (dec_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      grant    <= '0;
      alu_sel  <= '0;
      alu_busy <= 1'b0;
      done     <= '0;
`ifdef ALU_SCHED_RR_EN
      ptr      <= 2'd3;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (any_req) begin
            state    <= EXEC;
            op_q     <= op_sel;
            cnt      <= lat_sel - 4'd1;
            grant    <= 4'b0001 << win_nx;
            alu_sel  <= dec_sel;
            alu_busy <= 1'b1;
`ifdef ALU_SCHED_RR_EN
            ptr      <= win_nx;
`endif
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            state   <= DONE;
            done    <= grant;
            grant   <= '0;
            alu_sel <= '0;
          end else begin
            cnt     <= cnt - 4'd1;
            alu_sel <= dec_sel;
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= '0;
          alu_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler: stimulus queues expected busy-cycle outputs, a monitor checks them.
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] op_i;
  logic [3:0]  grant;
  logic [15:0] alu_sel;
  logic        alu_busy;
  logic [3:0]  done;

  int checks   = 0;
  int failures = 0;
  int idle_run = 0;

  typedef struct {
    logic [3:0]  g;
    logic [15:0] s;
    logic [3:0]  d;
    int          gap;
  } exp_t;

  exp_t sbq[$];

  alu_op_scheduler #(.LONG_LAT(4), .LONG_OP_BASE(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .op_i     (op_i),
    .grant    (grant),
    .alu_sel  (alu_sel),
    .alu_busy (alu_busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Monitor: every busy cycle consumes one expected entry; idle cycles must be all-zero.
  always @(negedge clk) begin
    exp_t e;
    if (alu_busy) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_busy grant=%b alu_sel=%h done=%b required=no activity",
                 grant, alu_sel, done);
      end else begin
        e = sbq.pop_front();
        if ({grant, alu_sel, done} !== {e.g, e.s, e.d}) begin
          failures++;
          $display("FAIL busy_cycle grant=%b alu_sel=%h done=%b required grant=%b alu_sel=%h done=%b",
                   grant, alu_sel, done, e.g, e.s, e.d);
        end
        if (e.gap >= 0) begin
          checks++;
          if (idle_run != e.gap) begin
            failures++;
            $display("FAIL grant_gap idle_cycles=%0d required=%0d", idle_run, e.gap);
          end
        end
      end
      idle_run = 0;
    end else begin
      checks++;
      if ({grant, alu_sel, done} !== '0) begin
        failures++;
        $display("FAIL idle_outputs grant=%b alu_sel=%h done=%b required=all zero",
                 grant, alu_sel, done);
      end
      idle_run++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  task automatic push_op(input logic [3:0] g, input logic [15:0] s, input int lat,
                         input int gap, input bit with_done);
    exp_t e;
    for (int i = 0; i < lat; i++) begin
      e.g = g; e.s = s; e.d = '0; e.gap = (i == 0) ? gap : -1;
      sbq.push_back(e);
    end
    if (with_done) begin
      e.g = '0; e.s = '0; e.d = g; e.gap = -1;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, output logic [3:0] d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 40);
    d = done;
    if (done == '0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout done=%b required=nonzero", name, done);
    end
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == '0 && n < 40);
    if (grant == '0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout grant=%b required=nonzero", name, grant);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [3:0] d;

    // Reset held with all requests pending: outputs must stay zero.
    rst_n = 1'b0;
    req   = 4'b1111;
    op_i  = 16'hC5D1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_alu_sel", 32'(alu_sel), 32'h0);
      chk("reset_busy", 32'(alu_busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
    end

    // All four requesting continuously; requester 0 wins first.
`ifdef ALU_SCHED_RR_EN
    push_op(4'b0001, 16'h0002, 1, -1, 1);
    push_op(4'b0010, 16'h2000, 4, 1, 1);
    push_op(4'b0100, 16'h0020, 1, 1, 1);
    push_op(4'b1000, 16'h1000, 4, 1, 1);
    push_op(4'b0001, 16'h0002, 1, 1, 1);
`else
    push_op(4'b0001, 16'h0002, 1, -1, 1);
    for (int i = 0; i < 4; i++) push_op(4'b0001, 16'h0002, 1, 1, 1);
`endif
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_done("arb", d);
      if (k == 4) begin
        req = '0;
      end else begin
        req = req & ~d;
        @(negedge clk);
        req = req | d;
      end
    end
    wait_drain();
    repeat (2) @(negedge clk);

    // Short op from requester 2.
    op_i = 16'h0500;
    req  = 4'b0100;
    push_op(4'b0100, 16'h0020, 1, -1, 1);
    wait_done("short", d);
    req = '0;
    wait_drain();
    repeat (2) @(negedge clk);

    // Long op from requester 1; opcode change mid-EXEC is ignored.
    op_i = 16'h00D0;
    req  = 4'b0010;
    push_op(4'b0010, 16'h2000, 4, -1, 1);
    wait_grant("long");
    @(negedge clk);
    op_i = 16'h0030;
    wait_done("long", d);
    req = '0;
    wait_drain();
    repeat (2) @(negedge clk);

    // Reset in the second EXEC cycle of a long op aborts it without done.
    op_i = 16'hC000;
    req  = 4'b1000;
    push_op(4'b1000, 16'h1000, 2, -1, 0);
    wait_grant("abort");
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("abort_alu_sel", 32'(alu_sel), 32'h0);
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_busy", 32'(alu_busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    wait_drain();

    // Sticky request: owner holds req one cycle past done and is re-granted.
    op_i = 16'h0500;
    req  = 4'b0100;
    push_op(4'b0100, 16'h0020, 1, -1, 1);
    push_op(4'b0100, 16'h0020, 1, 1, 1);
    wait_done("sticky1", d);
    @(negedge clk);
    @(negedge clk);
    req = '0;
    wait_done("sticky2", d);
    wait_drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Sequences shared use of the ALU among four requesters. It arbitrates pending requests, latches the winner's 4-bit opcode, and drives the ALU's 16-bit one-hot function select for the opcode's execution latency. It then returns a one-cycle completion pulse to the winner. It sits between the requester ports and the ALU datapath; it is the only driver of the ALU function select.

## Interface
- `LONG_LAT`, default 4: execution cycles for long opcodes (range 2..15).
- `LONG_OP_BASE`, default 12: opcodes >= this value are long; all lower opcodes take 1 cycle.
- `clk`  in  1  single clock; all logic is updated on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  4  request per requester; must be held until that requester's `done` bit pulses.
- `op_i`  in  16  opcodes; requester i drives `op_i[4i+3:4i]`, stable while its `req` is high.
- `grant`  out  4  one-hot owner of the ALU; high from the first EXEC cycle through the last EXEC cycle.
- `alu_sel`  out  16  one-hot ALU function select; all zero when no operation is executing.
- `alu_busy`  out  1  high in EXEC and DONE.
- `done`  out  4  one-cycle completion pulse to the owner.

## Operation
- State machine: IDLE, EXEC, DONE.
- **IDLE:** `req` is sampled here only.
  - If any bit is set: pick a winner, latch its opcode, load the counter with latency-1 (0 for short, LONG_LAT-1 for long), go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC:** `alu_sel` = one-hot(latched op) and `grant[w]` = 1.
  - The counter decrements each cycle. At counter == 0, go to DONE.
- **DONE:** `done[w]` = 1 for exactly one cycle; `grant` = 0 and `alu_sel` = 0. Go to IDLE.
- The opcode is latched at grant. Changes to `op_i` during EXEC or DONE are ignored.
- A `req` deasserted mid-operation does not abort it; the operation completes and `done` still pulses.
- A requester must drop `req` in the cycle `done` is seen. If `req` is still high in the following IDLE cycle, it is treated as a new request.
- Arbitration is round-robin (see Configuration).
  - The search starts at last winner + 1, mod 4.
  - The last-winner pointer resets to 3, so requester 0 wins first.
  - Simultaneous requests in the same IDLE cycle are resolved by the pointer alone.
- Reset values: `grant` = 0, `alu_sel` = 0, `alu_busy` = 0, `done` = 0, state = IDLE, counter = 0, pointer = 3.
- Reset asserted mid-operation aborts it silently: no `done` pulse, and all outputs are zero in the cycle after the reset edge.

## Timing
- All outputs are registered.
- With `req` first high in IDLE at cycle 0:
  - `grant` and `alu_sel` are valid in cycles 1..L.
  - `done` pulses in cycle L+1.
  - The next grant is possible in cycle L+3 (IDLE in L+2).
- Short op: L = 1, so 3 cycles from IDLE to IDLE. Long op: L = LONG_LAT.
- `alu_sel` is never non-zero outside EXEC. It changes only on transitions into or out of EXEC.
- `done` and `grant` are never high in the same cycle.

## Configuration
- `ALU_SCHED_RR_EN` defined: round-robin arbitration with the last-winner pointer, as described above.
- `ALU_SCHED_RR_EN` undefined:
  - Fixed priority; `req[0]` is highest and `req[3]` lowest.
  - The pointer register is not built.
  - All other behaviour and timing are identical.

## Structure
- Package `alu_sched_pkg`, holding:
  - the state enum (IDLE, EXEC, DONE);
  - `NREQ` = 4 and `OPW` = 4;
  - default values for `LONG_LAT` and `LONG_OP_BASE`;
  - a function returning the latency for an opcode.
- Sub-module `op_onehot_decode`: a purely combinational 4-to-16 one-hot decode of the latched opcode.
  - Its output is registered into `alu_sel` in the top.
  - This decode is the only path to `alu_sel`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with `req` = 4'b1111 -> all outputs 0. After release, the first grant is `grant` = 4'b0001.
- **Short op:** `req[2]` = 1, `op_i[11:8]` = 4'h5 -> `alu_sel` = 16'h0020 for exactly 1 cycle with `grant` = 4'b0100, then `done` = 4'b0100 for 1 cycle.
- **Long op:** `req[1]` = 1, op = 4'hD, LONG_LAT = 4 -> `alu_sel` = 16'h2000 for 4 cycles, then `done[1]` pulses. Changing `op_i` mid-EXEC has no effect.
- **Round-robin:** `req` = 4'b1111 held, each requester dropping `req` on its `done` and re-raising it one cycle later -> grant order 0, 1, 2, 3, 0.
  - With `ALU_SCHED_RR_EN` undefined, requester 0 wins every arbitration.
- **Abort:** `rst_n` = 0 in the second EXEC cycle of a long op -> no `done` pulse; `alu_sel` = 0 in the next cycle.
- **Sticky request:** owner keeps `req` high one cycle past `done`, with no other request -> it is re-granted starting 2 cycles after `done`.
